// File: rtl/fast_square_comb_decim.sv
// rtl/fast_square_comb_decim.sv - I/Q comb cascade with saturation, decimation and warmup blanking
module fast_square_comb_decim #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int DELAY  = 1,
    parameter int DECIM  = 16,
    parameter int WARMUP = 201
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_strobe,
    input  logic                    restart,
    input  logic                    bypass,
    input  logic signed [WIDTH-1:0] i_in,
    input  logic signed [WIDTH-1:0] q_in,
    output logic signed [WIDTH-1:0] i_out,
    output logic signed [WIDTH-1:0] q_out,
    output logic                    data_out_strobe,
    output logic                    warm
);
    localparam int CW = $clog2(DECIM);
    localparam int WW = $clog2(WARMUP + 2);
    localparam logic signed [WIDTH-1:0] P_MARK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] P_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] P_NEG  = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
    localparam logic signed [WIDTH:0]   P_HI   = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0]   P_LO   = {2'b11, {(WIDTH-2){1'b0}}, 1'b1};

    // Differences are formed one bit wider, then clamped off the reserved marker code.
    function automatic logic signed [WIDTH-1:0] f_sub_sat(input logic signed [WIDTH-1:0] a,
                                                           input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH:0] d;
        d = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (d > P_HI)
            return P_POS;
        else if (d < P_LO)
            return P_NEG;
        else
            return d[WIDTH-1:0];
    endfunction

    logic signed [WIDTH-1:0] r_i_stg [STAGES];
    logic signed [WIDTH-1:0] r_q_stg [STAGES];
    logic signed [WIDTH-1:0] r_i_dl  [STAGES][DELAY];
    logic signed [WIDTH-1:0] r_q_dl  [STAGES][DELAY];
    logic signed [WIDTH-1:0] w_i_x   [STAGES];
    logic signed [WIDTH-1:0] w_q_x   [STAGES];
    logic signed [WIDTH-1:0] w_i_y   [STAGES];
    logic signed [WIDTH-1:0] w_q_y   [STAGES];
    logic signed [WIDTH-1:0] r_i_data, r_q_data;
    logic signed [WIDTH-1:0] w_i_fin, w_q_fin;
    logic [CW-1:0]           r_dcnt;
    logic [WW-1:0]           r_wcnt;
    logic                    r_bypass;
    logic                    r_strobe;
    logic                    w_accept, w_wrap, w_byp_chg;

    assign w_accept  = in_strobe & ~restart;
    assign w_wrap    = w_accept && (r_dcnt == CW'(DECIM - 1));
    assign w_byp_chg = w_accept && (bypass != r_bypass);
    assign w_i_fin   = bypass ? ((i_in == P_MARK) ? P_NEG : i_in) : r_i_stg[STAGES-1];
    assign w_q_fin   = bypass ? ((q_in == P_MARK) ? P_NEG : q_in) : r_q_stg[STAGES-1];

    always_comb begin
        w_i_x[0] = i_in;
        w_q_x[0] = q_in;
        for (int s = 1; s < STAGES; s++) begin
            w_i_x[s] = r_i_stg[s-1];
            w_q_x[s] = r_q_stg[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            w_i_y[s] = f_sub_sat(w_i_x[s], r_i_dl[s][DELAY-1]);
            w_q_y[s] = f_sub_sat(w_q_x[s], r_q_dl[s][DELAY-1]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r_i_stg[s] <= '0;
                r_q_stg[s] <= '0;
                for (int k = 0; k < DELAY; k++) begin
                    r_i_dl[s][k] <= '0;
                    r_q_dl[s][k] <= '0;
                end
            end
            r_i_data <= '0;
            r_q_data <= '0;
            r_dcnt   <= '0;
            r_wcnt   <= '0;
            r_bypass <= 1'b0;
            r_strobe <= 1'b0;
        end else if (restart) begin
            for (int s = 0; s < STAGES; s++) begin
                r_i_stg[s] <= '0;
                r_q_stg[s] <= '0;
                for (int k = 0; k < DELAY; k++) begin
                    r_i_dl[s][k] <= '0;
                    r_q_dl[s][k] <= '0;
                end
            end
            r_dcnt   <= '0;
            r_wcnt   <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_accept) begin
                for (int s = 0; s < STAGES; s++) begin
                    r_i_stg[s]   <= w_i_y[s];
                    r_q_stg[s]   <= w_q_y[s];
                    r_i_dl[s][0] <= w_i_x[s];
                    r_q_dl[s][0] <= w_q_x[s];
                    for (int k = 1; k < DELAY; k++) begin
                        r_i_dl[s][k] <= r_i_dl[s][k-1];
                        r_q_dl[s][k] <= r_q_dl[s][k-1];
                    end
                end
                r_bypass <= bypass;
                r_dcnt   <= w_wrap ? '0 : r_dcnt + CW'(1);
                if (w_wrap) begin
                    r_i_data <= w_i_fin;
                    r_q_data <= w_q_fin;
                    r_strobe <= 1'b1;
                end
                // Counted at the wrap so warm is already high during the WARMUP-th strobe.
                if (w_byp_chg)
                    r_wcnt <= '0;
                else if (w_wrap && (r_wcnt != WW'(WARMUP)))
                    r_wcnt <= r_wcnt + WW'(1);
            end
        end
    end

    assign warm            = (r_wcnt == WW'(WARMUP));
    assign i_out           = warm ? r_i_data : P_MARK;
    assign q_out           = warm ? r_q_data : P_MARK;
    assign data_out_strobe = r_strobe;
endmodule
